// File: rtl/next_mon_pkg.sv
// Shared definitions for both ends of the NeXT monitor serial link:
// frame geometry, line levels, FSM state types and packet opcodes.
package next_mon_pkg;

  localparam int FRAME_W = 40;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Opcode byte in bits [39:32]; the soundbox decoder/encoder uses the same values.
  localparam logic [7:0] OP_POWER_ON    = 8'hC0;
  localparam logic [7:0] OP_SND_OUT     = 8'hC7;
  localparam logic [7:0] OP_SND_OUT_REQ = 8'hC3;
  localparam logic [7:0] OP_MIC_DATA    = 8'hC5;
  localparam logic [7:0] OP_KEYBOARD    = 8'hCD;
  localparam logic [7:0] OP_MOUSE       = 8'hCE;
  localparam logic [7:0] OP_KBD_LEDS    = 8'hCF;

  function automatic logic [FRAME_W-1:0] mk_packet(input logic [7:0]  op,
                                                   input logic [31:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/next_mon_frame_rx.sv
// Link deserializer: start bit, W data bits MSB-first, stop bit.
// A bad stop bit reports a framing error and waits for the line to go idle.
module next_mon_frame_rx
  import next_mon_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         mon_clk,
  input  logic         hw_reset_n,
  input  logic         ser_in,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         frame_err
);

  localparam int              CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);

  rx_state_e        state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      state_q <= RX_IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (ser_in == START_BIT) begin
          state_d = RX_DATA;
          cnt_d   = '0;
        end
      end
      RX_DATA: begin
        shreg_d = {shreg_q[W-2:0], ser_in};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          state_d = RX_STOP;
          cnt_d   = '0;
        end
      end
      RX_STOP: begin
        if (ser_in == LINE_IDLE) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          state_d = RX_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = RX_BREAK;
        end
      end
      RX_BREAK: begin
        // Line held low after a bad stop bit: do not mistake it for a start bit.
        if (ser_in == LINE_IDLE) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;

endmodule

// File: rtl/next_mon_host.sv
// Host end of the NeXT monitor link: TX serializer FSM driving to_mon, plus
// the shared frame receiver on from_mon. TX and RX run fully independently.
module next_mon_host
  import next_mon_pkg::*;
#(
  parameter int W   = FRAME_W,
  parameter int GAP = 4
) (
  input  logic         mon_clk,
  input  logic         hw_reset_n,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         tx_busy,
  output logic         to_mon,
  input  logic         from_mon,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic         rx_frame_err
);

  localparam int               CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e        tx_state_q, tx_state_d;
  logic [W-1:0]     tx_shreg_q, tx_shreg_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_shreg_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shreg_q <= tx_shreg_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shreg_d = tx_shreg_q;
    tx_cnt_d   = tx_cnt_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_shreg_d = tx_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_shreg_d = {tx_shreg_q[W-2:0], 1'b0};
        tx_cnt_d   = tx_cnt_q + 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_d   = '0;
        tx_state_d = (GAP > 0) ? TX_GAP : TX_IDLE;
      end
      TX_GAP: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == GAP_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Line level decoded from state so an async reset returns it high at once.
  always_comb begin
    to_mon = LINE_IDLE;
    case (tx_state_q)
      TX_START: to_mon = START_BIT;
      TX_DATA:  to_mon = tx_shreg_q[W-1];
      default:  to_mon = LINE_IDLE;
    endcase
  end

  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_ready = !tx_busy;

  next_mon_frame_rx #(
    .W(W)
  ) u_rx (
    .mon_clk    (mon_clk),
    .hw_reset_n (hw_reset_n),
    .ser_in     (from_mon),
    .data       (rx_data),
    .valid      (rx_valid),
    .frame_err  (rx_frame_err)
  );

endmodule

// File: doc/next_mon_host.md
# next_mon_host

Host-side endpoint of the NeXT monitor serial link: the CPU end that emulates the computer while the soundbox emulation is the device end. It serializes 40-bit command/audio packets onto `to_mon` and deserializes 40-bit reply packets (keyboard, mouse, mic, power-on) from `from_mon`. Everything runs in the `mon_clk` domain, which the host owns. It is used as a bench/bring-up master for the soundbox and as the link core of a host-side adapter.

## Interface
Parameters:
- `W`, 40, packet width in bits: 8-bit opcode byte plus 32-bit payload.
- `GAP`, 4, minimum idle-high `mon_clk` cycles after each transmitted stop bit, range 0..15.

Ports:
- `mon_clk`, in, 1, link clock. This is the only clock.
- `hw_reset_n`, in, 1, asynchronous active-low reset.
- `tx_data`, in, W, packet to send. Bit W-1 is sent first.
- `tx_valid`, in, 1, `tx_data` is valid.
- `tx_ready`, out, 1, the transmitter accepts `tx_data` this cycle.
- `tx_busy`, out, 1, a frame or its gap is in progress.
- `to_mon`, out, 1, serial line to the device. It idles high.
- `from_mon`, in, 1, serial line from the device. It is synchronous to `mon_clk` and idles high.
- `rx_data`, out, W, last good received packet.
- `rx_valid`, out, 1, one-cycle pulse when `rx_data` has been updated.
- `rx_frame_err`, out, 1, one-cycle pulse when a stop bit is bad.

## Operation
- Frame format: start bit 0, then W data bits MSB-first, then stop bit 1, with one bit per `mon_clk` cycle.
- TX FSM states:
  - IDLE: `tx_ready`=1 and `to_mon`=1. On `tx_valid & tx_ready`, load the shift register and go to START.
  - START: `to_mon`=0. Go to DATA.
  - DATA: `to_mon`=shreg[W-1], then shift left. Stay for W cycles using a bit counter of width clog2(W+1), then go to STOP.
  - STOP: `to_mon`=1. Go to GAP if GAP>0, otherwise go to IDLE.
  - GAP: `to_mon`=1 for GAP cycles, then go to IDLE.
- `tx_busy` is 1 whenever the TX FSM is not in IDLE. `tx_ready` is exactly `!tx_busy`.
- `tx_data` is sampled only on the handshake cycle. Later changes to it have no effect on the frame in flight.
- RX FSM states:
  - IDLE: when `from_mon`==0, go to DATA.
  - DATA: shift in W bits MSB-first, then go to STOP.
  - STOP: if `from_mon`==1, register the shift value into `rx_data` and pulse `rx_valid`, then go to IDLE. If `from_mon`==0, pulse `rx_frame_err`, leave `rx_data` unchanged, and go to BREAK.
  - BREAK: wait for `from_mon`==1, then go to IDLE.
- TX and RX are fully independent (full duplex). Simultaneous activity on both never stalls either side.
- Reset values: `to_mon`=1, `tx_ready`=1, `tx_busy`=0, `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0. Both FSMs start in IDLE.

## Timing
- TX timeline for a handshake at cycle N:
  - `to_mon` is 0 at N+1.
  - Data bits appear at N+2..N+W+1.
  - The stop bit appears at N+W+2.
  - `tx_ready` returns at N+W+3+GAP.
- Back-to-back frame period with `tx_valid` held high is W+3+GAP cycles (47 with defaults).
- RX timeline for a start bit sampled at cycle S:
  - Data bits are sampled at S+1..S+W.
  - The stop bit is sampled at S+W+1.
  - `rx_valid` or `rx_frame_err` is high during S+W+2.
  - `rx_data` is stable from S+W+2 until the next good frame.
- A new RX start bit is accepted during the `rx_valid` cycle itself. The minimum RX frame spacing is therefore W+2 cycles.
- An async reset in mid-frame forces `to_mon` high immediately and discards any partial RX shift contents. No `rx_valid` or `rx_frame_err` pulse is produced for a truncated frame.
- The `tx_valid`/`tx_ready` handshake follows standard valid/ready rules. There is no combinational path from `tx_valid` to `tx_ready`.

## Structure
- Shared package `next_mon_pkg` holds:
  - `FRAME_W`=40.
  - The `LINE_IDLE`=1'b1 and `START_BIT`=1'b0 constants.
  - The TX and RX state enums.
  - The opcode byte constants used by the soundbox decoder/encoder pair, so both ends share them.
- Sub-module `next_mon_frame_rx` contains the RX FSM and deserializer. It is also reusable device-side.
- The TX FSM lives in `next_mon_host`.

## Test plan
- Single TX: send `tx_data`=40'hA5_0000_1234 → `to_mon` shows 0, then the 40 bits MSB-first, then 1. `tx_ready` is low for 46 cycles, then high.
- Back-to-back TX: hold `tx_valid` high with two words → the second start bit is exactly 47 cycles after the first. Modifying `tx_data` mid-frame does not corrupt the first frame.
- RX good frame: drive a start bit, then 40'h0F_DEAD_BEEF, then 1 → a single `rx_valid` pulse at S+42 with `rx_data`=40'h0F_DEAD_BEEF, and no `rx_frame_err`.
- RX framing error: drive a frame whose stop bit is 0, with the line then low for 10 cycles → one `rx_frame_err` pulse, no `rx_valid`, and `rx_data` retains its prior value. The next valid frame is received correctly.
- Loopback: tie `to_mon` to `from_mon` and send 100 random words → 100 `rx_valid` pulses, in order and bit-exact, with zero errors.
- Reset mid-operation: assert `hw_reset_n` during TX data bit 20 and RX data bit 10 → `to_mon`=1 asynchronously, all outputs return to their reset values, and the next frame after release is correct.
